// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the dual-lane data-memory arbiter.
//   arb_state_e : IDLE (normal) / SECOND (buffered lane-2 access in flight)
//   dmem_req_t  : one lane's memory request {we, addr, wdata} at default widths
package dmem_arb_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: lane request/response signals plus the dmem port.
//   slave  : arbiter side (takes lane requests and q_dmem, drives dmem + results)
//   master : pipeline/memory side
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req_1, req_2;
  logic              we_1, we_2;
  logic [ADDR_W-1:0] addr_1, addr_2;
  logic [DATA_W-1:0] wdata_1, wdata_2;
  logic              stall;
  logic [DATA_W-1:0] rdata_1, rdata_2;
  logic              rvalid_1, rvalid_2;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  req_1, req_2, we_1, we_2, addr_1, addr_2, wdata_1, wdata_2, q_dmem,
    output stall, rdata_1, rdata_2, rvalid_1, rvalid_2, address_dmem, data, wren
  );

  modport master (
    output req_1, req_2, we_1, we_2, addr_1, addr_2, wdata_1, wdata_2, q_dmem,
    input  stall, rdata_1, rdata_2, rvalid_1, rvalid_2, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port dmem between two issue lanes.
// Lane 1 is the older instruction; a same-bundle conflict grants lane 1 with a
// one-cycle stall, buffers lane 2, and replays it the next cycle.
// Ports:
//   clock, reset       : master clock (dmem uses ~clock), async active-high reset
//   bus (slave)        : lane requests, dmem address/data/wren/q, stall,
//                        registered per-lane rdata/rvalid
//   conflict_count     : saturating count of serialized bundles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  dmem_arbiter_if.slave      bus,
  output logic [CNT_W-1:0]   conflict_count
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lane_req_t;

  arb_state_e                 state_q, state_d;
  lane_req_t                  buf_q, buf_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0][DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]                 rvalid_q, rvalid_d;
  logic [1:0]                 ld;
  logic                       stall_c, wren_c;
  logic [ADDR_W-1:0]          addr_c;
  logic [DATA_W-1:0]          data_c;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    wren_c   = 1'b0;
    addr_c   = '0;
    data_c   = '0;
    ld       = '0;
    // reset forces the dmem port quiet even mid-cycle, so a buffered store
    // cannot land while reset is asserted
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_1) begin
            wren_c = bus.we_1;
            addr_c = bus.addr_1;
            data_c = bus.wdata_1;
            ld[0]  = !bus.we_1;
            if (bus.req_2) begin
              stall_c = 1'b1;
              buf_d   = '{we: bus.we_2, addr: bus.addr_2, wdata: bus.wdata_2};
              cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
              state_d = SECOND;
            end
          end else if (bus.req_2) begin
            wren_c = bus.we_2;
            addr_c = bus.addr_2;
            data_c = bus.wdata_2;
            ld[1]  = !bus.we_2;
          end
        end
        SECOND: begin
          // lane inputs are the same stalled bundle; only the buffer matters
          wren_c  = buf_q.we;
          addr_c  = buf_q.addr;
          data_c  = buf_q.wdata;
          ld[1]   = !buf_q.we;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // load data is captured at the end of the grant cycle; q_dmem only feeds flops
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ld;
    for (int i = 0; i < 2; i++)
      if (ld[i]) rdata_d[i] = bus.q_dmem;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.wren         = wren_c;
  assign bus.address_dmem = addr_c;
  assign bus.data         = data_c;
  assign bus.rdata_1      = rdata_q[0];
  assign bus.rdata_2      = rdata_q[1];
  assign bus.rvalid_1     = rvalid_q[0];
  assign bus.rvalid_2     = rvalid_q[1];
  assign conflict_count   = cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus_s ();
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .conflict_count(cnt));
  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s.slave), .conflict_count(cnt_s));

  // dmem: clocked on the falling edge, read-before-write
  logic [31:0] mem [0:4095];
  logic [31:0] q_r;
  always @(negedge clock) begin
    if (bus.wren) mem[bus.address_dmem] <= bus.data;
    q_r <= mem[bus.address_dmem];
  end
  assign bus.q_dmem   = q_r;
  assign bus_s.q_dmem = 32'h0;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [0:4095];
  dmem_req_t   pend[$];
  logic [1:0][31:0] m_rd;
  logic [1:0]  m_rv;
  logic [31:0] m_cnt;
  bit          logging = 0;
  bit          stall_log[$];
  int          addr_log[$];

  always @(negedge clock) begin
    dmem_req_t a;
    bit        have;
    int        lane;
    bit        e_stall;
    if (reset) begin
      chk("rst_stall", bus.stall, 0);
      chk("rst_wren", bus.wren, 0);
      chk("rst_addr", bus.address_dmem, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_rv", {bus.rvalid_2, bus.rvalid_1}, 0);
      chk("rst_rd", {bus.rdata_2, bus.rdata_1}, 0);
      chk("rst_cnt", cnt, 0);
      pend.delete();
      m_rd = '0; m_rv = '0; m_cnt = 0;
    end else begin
      have = 0; lane = 0; e_stall = 0; a = '0;
      if (pend.size() > 0) begin
        a = pend.pop_front(); have = 1; lane = 1;
      end else if (bus.req_1) begin
        a = '{bus.we_1, bus.addr_1, bus.wdata_1}; have = 1; lane = 0;
        if (bus.req_2) begin
          e_stall = 1;
          pend.push_back('{bus.we_2, bus.addr_2, bus.wdata_2});
        end
      end else if (bus.req_2) begin
        a = '{bus.we_2, bus.addr_2, bus.wdata_2}; have = 1; lane = 1;
      end
      chk("stall", bus.stall, e_stall);
      chk("wren", bus.wren, have & a.we);
      chk("addr", bus.address_dmem, have ? a.addr : 0);
      chk("data", bus.data, have ? a.wdata : 0);
      chk("rvalid_1", bus.rvalid_1, m_rv[0]);
      chk("rvalid_2", bus.rvalid_2, m_rv[1]);
      chk("rdata_1", bus.rdata_1, m_rd[0]);
      chk("rdata_2", bus.rdata_2, m_rd[1]);
      chk("count", cnt, m_cnt);
      if (logging) begin
        stall_log.push_back(bus.stall);
        addr_log.push_back(int'(bus.address_dmem));
      end
      m_rv = '0;
      if (have) begin
        if (a.we) mem_m[a.addr] = a.wdata;
        else begin m_rd[lane] = mem_m[a.addr]; m_rv[lane] = 1; end
      end
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input int ad, input logic [31:0] v);
    mem[ad] = v; mem_m[ad] = v;
  endtask

  task automatic idle_in();
    bus.req_1 = 0; bus.req_2 = 0; bus.we_1 = 0; bus.we_2 = 0;
    bus.addr_1 = 0; bus.addr_2 = 0; bus.wdata_1 = 0; bus.wdata_2 = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drive(input bit r1, w1, input int a1, input logic [31:0] d1,
                       input bit r2, w2, input int a2, input logic [31:0] d2);
    bus.req_1 = r1; bus.we_1 = w1; bus.addr_1 = 12'(a1); bus.wdata_1 = d1;
    bus.req_2 = r2; bus.we_2 = w2; bus.addr_2 = 12'(a2); bus.wdata_2 = d2;
  endtask

  // one bundle; held for the stall cycle when both lanes request
  task automatic bundle(input bit r1, w1, input int a1, input logic [31:0] d1,
                        input bit r2, w2, input int a2, input logic [31:0] d2);
    drive(r1, w1, a1, d1, r2, w2, a2, d2);
    cyc((r1 && r2) ? 2 : 1);
  endtask

  task automatic do_reset();
    reset = 1; cyc(2); reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_in();
    bus_s.req_1 = 0; bus_s.req_2 = 0; bus_s.we_1 = 0; bus_s.we_2 = 0;
    bus_s.addr_1 = 0; bus_s.addr_2 = 0; bus_s.wdata_1 = 0; bus_s.wdata_2 = 0;
    for (int i = 0; i < 4096; i++) begin mem[i] = 0; mem_m[i] = 0; end
    cyc(2);
    chk("reset_cnt", cnt, 0);
    chk("reset_rdata_1", bus.rdata_1, 0);
    chk("reset_stall", bus.stall, 0);
    reset = 0;
    cyc(1);

    // single load
    preload(5, 32'hCAFE0001);
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    #1;
    chk("t1_addr", bus.address_dmem, 5);
    chk("t1_wren", bus.wren, 0);
    chk("t1_stall", bus.stall, 0);
    cyc(1); idle_in();
    chk("t1_rvalid_1", bus.rvalid_1, 1);
    chk("t1_rdata_1", bus.rdata_1, 32'hCAFE0001);
    chk("t1_rvalid_2", bus.rvalid_2, 0);
    cyc(1);
    chk("t1_rvalid_1_pulse", bus.rvalid_1, 0);
    chk("t1_rdata_1_held", bus.rdata_1, 32'hCAFE0001);
    // lane-2-only store then load
    bundle(0, 0, 0, 0, 1, 1, 20, 32'h0BAD_F00D);
    bundle(0, 0, 0, 0, 1, 0, 20, 0);
    idle_in(); cyc(1);
    chk("t1_rdata_2", bus.rdata_2, 32'h0BAD_F00D);

    // conflict: store then load same address
    do_reset();
    drive(1, 1, 9, 32'h12345678, 1, 0, 9, 0);
    #1;
    chk("t2_c0_stall", bus.stall, 1);
    chk("t2_c0_wren", bus.wren, 1);
    chk("t2_c0_addr", bus.address_dmem, 9);
    cyc(1);
    chk("t2_c1_wren", bus.wren, 0);
    chk("t2_c1_addr", bus.address_dmem, 9);
    chk("t2_c1_stall", bus.stall, 0);
    cyc(1); idle_in();
    chk("t2_rvalid_2", bus.rvalid_2, 1);
    chk("t2_rdata_2", bus.rdata_2, 32'h12345678);
    chk("t2_cnt", cnt, 1);

    // conflict: load then store same address
    preload(3, 32'hAA);
    drive(1, 0, 3, 0, 1, 1, 3, 32'hBB);
    cyc(1);
    chk("t3_rvalid_1", bus.rvalid_1, 1);
    chk("t3_rdata_1", bus.rdata_1, 32'hAA);
    cyc(1); idle_in(); cyc(2);
    chk("t3_mem3", mem[3], 32'hBB);
    chk("t3_cnt", cnt, 2);

    // back-to-back conflict bundles
    do_reset();
    stall_log.delete(); addr_log.delete();
    logging = 1;
    bundle(1, 1, 1, 32'h101, 1, 0, 2, 0);
    bundle(1, 0, 3, 0, 1, 1, 4, 32'h404);
    bundle(1, 1, 5, 32'h505, 1, 1, 6, 32'h606);
    logging = 0;
    idle_in(); cyc(2);
    chk("t4_log_len", stall_log.size(), 6);
    for (int i = 0; i < 6 && i < stall_log.size(); i++) begin
      chk("t4_stall_pat", stall_log[i], (i % 2 == 0));
      chk("t4_addr_order", addr_log[i], i + 1);
    end
    chk("t4_cnt", cnt, 3);
    chk("t4_mem6", mem[6], 32'h606);

    // reset during SECOND with a buffered lane-2 store
    preload(8, 32'h11);
    drive(1, 0, 7, 0, 1, 1, 8, 32'h55);
    cyc(1);
    chk("t5_second_wren", bus.wren, 1);
    chk("t5_second_addr", bus.address_dmem, 8);
    #1 reset = 1;
    #1;
    chk("t5_rst_wren", bus.wren, 0);
    chk("t5_rst_addr", bus.address_dmem, 0);
    chk("t5_rst_stall", bus.stall, 0);
    @(posedge clock); #1;
    idle_in(); reset = 0;
    chk("t5_cnt", cnt, 0);
    chk("t5_rdata_1", bus.rdata_1, 0);
    chk("t5_rdata_2", bus.rdata_2, 0);
    cyc(3);
    chk("t5_mem8", mem[8], 32'h11);
    bundle(0, 0, 0, 0, 1, 0, 8, 0);
    idle_in(); cyc(1);
    chk("t5_reload", bus.rdata_2, 32'h11);

    // saturation on the 4-bit counter instance
    do_reset();
    bus_s.req_1 = 1; bus_s.req_2 = 1;
    for (int i = 0; i < 17; i++) begin
      cyc(2);
      chk("t6_sat_cnt", cnt_s, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("t6_sat_final", cnt_s, 4'hF);
    bus_s.req_1 = 0; bus_s.req_2 = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
